// File: rtl/pipe_mac_array.sv
// pipe_mac_array: LANES-wide signed multiply / adder-tree / window accumulator.
//
// Each accepted beat carries LANES signed if/filter element pairs. Their
// products are summed and added into a running window accumulator. The beat
// flagged in_last closes the window and emits the sum on out.
// Pipeline: S0 operand register, S1 lane products, S2 lane sum, S3 accumulate
// and output. A last beat accepted at edge t gives out_valid after edge t+3.
// Output backpressure (out_valid & ~out_ready) freezes the whole pipe.
//
// Optional feature: define PIPE_MAC_SAT_EN for saturating accumulation with a
// per-window sticky overflow reported on sat_flag. When it is undefined the
// accumulator wraps modulo 2^OUT_W and sat_flag stays 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clear      synchronous flush of pipe, accumulator and output
//   in_valid   / in_ready / in_last    input beat handshake and window end
//   if_in      LANES x IF_CELL_SIZE signed elements, lane i at [i*W +: W]
//   filter_in  LANES x FILTER_CELL_SIZE signed elements, packed likewise
//   out_valid  / out_ready             result handshake
//   out        signed window sum, OUT_W = IF + FILTER + ACC_GUARD bits
//   sat_flag   result was clamped (qualified by out_valid)
//   busy       any stage, held result or open window holds live data
module pipe_mac_array #(
    parameter int unsigned IF_CELL_SIZE     = 8,
    parameter int unsigned FILTER_CELL_SIZE = 8,
    parameter int unsigned LANES            = 4,
    parameter int unsigned ACC_GUARD        = 4
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     clear,
    input  logic                                                     in_valid,
    output logic                                                     in_ready,
    input  logic                                                     in_last,
    input  logic [LANES*IF_CELL_SIZE-1:0]                            if_in,
    input  logic [LANES*FILTER_CELL_SIZE-1:0]                        filter_in,
    output logic                                                     out_valid,
    input  logic                                                     out_ready,
    output logic signed [IF_CELL_SIZE+FILTER_CELL_SIZE+ACC_GUARD-1:0] out,
    output logic                                                     sat_flag,
    output logic                                                     busy
);

    localparam int unsigned PROD_W = IF_CELL_SIZE + FILTER_CELL_SIZE;
    localparam int unsigned OUT_W  = PROD_W + ACC_GUARD;

`ifdef PIPE_MAC_SAT_EN
    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    logic stall;
    logic accept;

    // S0: registered operands
    logic                              s0_valid;
    logic                              s0_last;
    logic [LANES*IF_CELL_SIZE-1:0]     s0_if;
    logic [LANES*FILTER_CELL_SIZE-1:0] s0_filter;

    // S1: per-lane products
    logic                     s1_valid;
    logic                     s1_last;
    logic signed [PROD_W-1:0] s1_prod [LANES];

    // S2: lane sum
    logic                    s2_valid;
    logic                    s2_last;
    logic signed [OUT_W-1:0] s2_sum;

    // S3: window accumulator state
    logic signed [OUT_W-1:0] acc;
    logic                    win_open;
    logic                    win_ovf;

    logic signed [PROD_W-1:0] prod_c [LANES];
    logic signed [OUT_W-1:0]  lane_sum_c;
    logic signed [OUT_W-1:0]  sum_c;
    logic                     ovf_c;
`ifdef PIPE_MAC_SAT_EN
    logic signed [OUT_W:0]    sum_wide;
`endif

    // Backpressure freezes every stage; clear forces readiness since it empties the output.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = clear | ~stall;
    assign accept   = in_valid & in_ready & ~clear;
    assign busy     = s0_valid | s1_valid | s2_valid | out_valid | win_open;

    // Lane multipliers on the registered operands
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_c[i] = PROD_W'($signed(s0_if[i*IF_CELL_SIZE +: IF_CELL_SIZE]))
                      * PROD_W'($signed(s0_filter[i*FILTER_CELL_SIZE +: FILTER_CELL_SIZE]));
        end
    end

    // Adder tree over sign-extended lane products
    always_comb begin
        lane_sum_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum_c = lane_sum_c + OUT_W'(s1_prod[i]);
        end
    end

    // Accumulate step; with saturation the sum is one bit wider and clamped
    always_comb begin
        ovf_c = 1'b0;
`ifdef PIPE_MAC_SAT_EN
        sum_wide = (OUT_W+1)'(acc) + (OUT_W+1)'(s2_sum);
        if (sum_wide[OUT_W] != sum_wide[OUT_W-1]) begin
            ovf_c = 1'b1;
            sum_c = sum_wide[OUT_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_c = sum_wide[OUT_W-1:0];
        end
`else
        sum_c = acc + s2_sum;
`endif
    end

    // Pipeline, accumulator and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid  <= 1'b0;
            s0_last   <= 1'b0;
            s0_if     <= '0;
            s0_filter <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_sum    <= '0;
            acc       <= '0;
            win_open  <= 1'b0;
            win_ovf   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            acc       <= '0;
            win_open  <= 1'b0;
            win_ovf   <= 1'b0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (!stall) begin
            s0_valid <= accept;
            s0_last  <= accept & in_last;
            if (accept) begin
                s0_if     <= if_in;
                s0_filter <= filter_in;
            end

            s1_valid <= s0_valid;
            s1_last  <= s0_last;
            if (s0_valid) begin
                s1_prod <= prod_c;
            end

            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_sum <= lane_sum_c;
            end

            // Not stalled: any held result is being taken this edge
            out_valid <= 1'b0;
            if (s2_valid) begin
                if (s2_last) begin
                    out       <= sum_c;
                    out_valid <= 1'b1;
                    sat_flag  <= win_ovf | ovf_c;
                    acc       <= '0;
                    win_open  <= 1'b0;
                    win_ovf   <= 1'b0;
                end else begin
                    acc      <= sum_c;
                    win_open <= 1'b1;
                    win_ovf  <= win_ovf | ovf_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_mac_array.sv
// Self-checking bench for pipe_mac_array (LANES=4, 8-bit elements, OUT_W=20).
// A behavioural window model pushes expected results to a queue as beats are
// accepted; a negedge monitor pops and compares on every output handshake.
module tb_pipe_mac_array;

    localparam int unsigned LANES = 4;
    localparam int unsigned OUT_W = 20;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              clear     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_last   = 1'b0;
    logic              out_ready = 1'b1;
    logic [31:0]       if_in     = '0;
    logic [31:0]       filter_in = '0;
    logic              in_ready;
    logic              out_valid;
    logic              sat_flag;
    logic              busy;
    logic signed [OUT_W-1:0] out;

    pipe_mac_array #(
        .IF_CELL_SIZE     (8),
        .FILTER_CELL_SIZE (8),
        .LANES            (LANES),
        .ACC_GUARD        (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .if_in     (if_in),
        .filter_in (filter_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .sat_flag  (sat_flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [OUT_W-1:0] val;
        logic                    sat;
    } exp_t;

    exp_t   exp_q[$];
    int     n_pass = 0;
    int     n_total = 0;
    int     ready_stalls = 0;
    longint m_acc = 0;
    bit     m_ovf = 1'b0;

    function automatic logic [31:0] rep(input int v);
        logic [7:0] b;
        b = 8'(v);
        return {4{b}};
    endfunction

    // Reference window model, advanced once per accepted beat
    task automatic model_beat(input logic [31:0] ifv, input logic [31:0] fv, input bit last);
        longint s;
        longint t;
        logic [7:0] a;
        logic [7:0] b;
        exp_t e;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            a = ifv[i*8 +: 8];
            b = fv[i*8 +: 8];
            s += longint'($signed(a)) * longint'($signed(b));
        end
        t = m_acc + s;
`ifdef PIPE_MAC_SAT_EN
        if (t > 524287) begin
            t = 524287;
            m_ovf = 1'b1;
        end else if (t < -524288) begin
            t = -524288;
            m_ovf = 1'b1;
        end
`else
        t = t % 1048576;
        if (t >= 524288) t -= 1048576;
        else if (t < -524288) t += 1048576;
`endif
        if (last) begin
            e.val = 20'(t);
            e.sat = m_ovf;
            exp_q.push_back(e);
            m_acc = 0;
            m_ovf = 1'b0;
        end else begin
            m_acc = t;
        end
    endtask

    // Present one beat and hold it until accepted; in_ready sampled at negedge
    task automatic drive_beat(input logic [31:0] ifv, input logic [31:0] fv, input bit last);
        int waited;
        waited    = 0;
        if_in     = ifv;
        filter_in = fv;
        in_last   = last;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            model_beat(ifv, fv, last);
            if (waited != 0) ready_stalls++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Scoreboard monitor: one comparison per output handshake
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && out_valid && out_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL result_unexpected: got out=%0d sat=%0b, required no result", out, sat_flag);
            end else begin
                e = exp_q.pop_front();
                if (out !== e.val || sat_flag !== e.sat)
                    $display("FAIL result: got out=%0d sat=%0b, required out=%0d sat=%0b",
                             out, sat_flag, e.val, e.sat);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, required 0", out_valid); else n_pass++;
        n_total++; if (out !== 20'sd0) $display("FAIL reset_out: got %0d, required 0", out); else n_pass++;
        n_total++; if (sat_flag !== 1'b0) $display("FAIL reset_sat: got %0b, required 0", sat_flag); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, required 0", busy); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, required 1", in_ready); else n_pass++;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive_beat(rep(3), rep(2), 1'b1);
        @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL lat_t1: got out_valid=%0b, required 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL busy_t1: got %0b, required 1", busy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL lat_t2: got out_valid=%0b, required 0", out_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b1 || out !== 20'sd24)
            $display("FAIL lat_t3: got out_valid=%0b out=%0d, required 1/24", out_valid, out); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL busy_after_hs: got %0b, required 0", busy); else n_pass++;
        wait_idle();
        n_total++; if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL single_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    task automatic test_multi_beat();
        drive_beat(rep(1), rep(1), 1'b0);
        drive_beat(rep(1), rep(2), 1'b0);
        drive_beat(rep(1), rep(3), 1'b1);
        // distinct per-lane values
        drive_beat(32'hFC03FE01, 32'h08F90605, 1'b0);
        drive_beat(32'h7F80017F, 32'h80807F01, 1'b1);
        wait_idle();
        n_total++; if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL multi_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        fork
            begin
                drive_beat(rep(3), rep(2), 1'b1);
                for (int k = 1; k <= 5; k++) drive_beat(rep(1), rep(k), k == 5);
            end
            begin
                int n;
                n = 0;
                @(posedge clk); #1;
                while (!out_valid && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                repeat (4) @(posedge clk);
                #1;
                n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %0b, required 0", in_ready); else n_pass++;
                n_total++; if (out_valid !== 1'b1 || out !== 20'sd24)
                    $display("FAIL stall_hold: got out_valid=%0b out=%0d, required 1/24", out_valid, out); else n_pass++;
                n_total++; if (busy !== 1'b1) $display("FAIL stall_busy: got %0b, required 1", busy); else n_pass++;
                out_ready = 1'b1;
            end
        join
        wait_idle();
        n_total++; if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL stall_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) drive_beat(rep(-128), rep(127), i == 8);
        wait_idle();
        n_total++; if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL sat_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    task automatic test_clear();
        drive_beat(rep(7), rep(9), 1'b0);
        drive_beat(rep(7), rep(9), 1'b0);
        // a last beat presented with clear must be dropped
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        if_in     = rep(5);
        filter_in = rep(5);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL clear_in_ready: got %0b, required 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_acc    = 0;
        m_ovf    = 1'b0;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL clear_flush: got out_valid=%0b busy=%0b, required 0/0", out_valid, busy); else n_pass++;
        drive_beat(rep(2), rep(5), 1'b1);
        wait_idle();
        n_total++; if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL clear_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        drive_beat(rep(3), rep(2), 1'b1);
        drive_beat(rep(1), rep(1), 1'b0);
        drive_beat(rep(1), rep(1), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b1 || out !== 20'sd24)
            $display("FAIL pre_rst_hold: got out_valid=%0b out=%0d, required 1/24", out_valid, out); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || out !== 20'sd0 || sat_flag !== 1'b0)
            $display("FAIL rst_async_out: got valid=%0b out=%0d sat=%0b, required 0/0/0", out_valid, out, sat_flag); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %0b, required 0", busy); else n_pass++;
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive_beat(rep(2), rep(5), 1'b1);
        wait_idle();
        n_total++; if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL rst_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gaps;
        gaps = 0;
        ready_stalls = 0;
        out_ready = 1'b1;
        fork
            begin
                logic [31:0] a;
                logic [31:0] b;
                for (int i = 0; i < 8; i++) begin
                    a = $urandom;
                    b = $urandom;
                    drive_beat(a, b, 1'b1);
                end
            end
            begin
                int n;
                n = 0;
                @(posedge clk); #1;
                while (!out_valid && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                for (int k = 0; k < 8; k++) begin
                    if (!out_valid || !in_ready) gaps++;
                    @(posedge clk); #1;
                end
            end
        join
        n_total++; if (gaps != 0) $display("FAIL b2b_gaps: got %0d bubble cycles, required 0", gaps); else n_pass++;
        n_total++; if (ready_stalls != 0) $display("FAIL b2b_in_ready: got %0d stalled beats, required 0", ready_stalls); else n_pass++;
        wait_idle();
        n_total++; if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL b2b_drain: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_beat();
        test_stall();
        test_saturation();
        test_clear();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/pipe_mac_array.md
Name: pipe_mac_array

Overview:
- Parametrised successor to the single-lane pipelined convolution MAC.
- LANES parallel signed multipliers feed an adder tree and a partial-sum accumulator.
- Result is emitted when the producer flags the last beat of a window (replaces par_done).
- Valid/ready handshakes on input and output; output backpressure stalls the whole pipe. Sits between the IF/filter buffer readers and the output-feature-map writer.

Parameters:
- IF_CELL_SIZE, 8, bit width of one signed input-feature element.
- FILTER_CELL_SIZE, 8, bit width of one signed filter element.
- LANES, 4, number of parallel multiply lanes (>=1, power of two not required).
- ACC_GUARD, 4, extra accumulator bits; OUT_W = IF_CELL_SIZE+FILTER_CELL_SIZE+ACC_GUARD.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort: flush pipe and accumulator.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipe can accept a beat.
- in_last  in  1  beat closes the current window.
- if_in  in  LANES*IF_CELL_SIZE  lane i at [i*IF_CELL_SIZE +: IF_CELL_SIZE], signed.
- filter_in  in  LANES*FILTER_CELL_SIZE  lane i packed likewise, signed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  OUT_W  signed window sum.
- sat_flag  out  1  result was clamped (qualified by out_valid).
- busy  out  1  any stage or accumulator holds live data.

Behaviour:
- Reset (rst=0, async): all stage valids 0, accumulator 0, out=0, out_valid=0, sat_flag=0, busy=0; in_ready=1 after release.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall. During stall every stage register, last flag and the accumulator hold.
- Beat accepted when in_valid & in_ready.
- S1 (cycle t+1): per-lane product if*filter registered, full width IF+FILTER, sign-extended, plus valid/last.
- S2 (t+2): lane products summed (sign-extended to OUT_W) and registered with valid/last.
- S3 (t+3): if S2 valid: sum = acc + lane_sum.
  - Not last: acc <= sum.
  - Last: out <= sum, out_valid <= 1, acc <= 0.
- Latency: last beat accepted at edge t gives out_valid=1 after edge t+3. Throughput 1 beat/cycle absent stall.
- Output: out_valid clears on out_valid & out_ready unless a new result loads the same edge; then the new result replaces it with no bubble.
- Window of one beat (in_valid & in_last with acc=0) is legal. Bubbles (in_valid=0) mid-window leave acc unchanged.
- clear=1 (sync, priority over everything except rst): all stage valids 0, acc 0, out_valid 0, sat_flag 0; any beat presented that cycle is dropped. in_ready remains ~stall evaluated after clear, i.e. 1.
- Arithmetic: two's complement. Without the optional feature, accumulation wraps modulo 2^OUT_W.
- busy = any stage valid | out_valid | (acc window open, i.e. a non-last beat accumulated since last result/clear).

Optional Feature:
- Macro PIPE_MAC_SAT_EN.
- Defined: the S3 sum is computed one bit wider. If it exceeds the OUT_W signed range, it clamps to 2^(OUT_W-1)-1 or -2^(OUT_W-1), and a sticky window overflow bit is set. The window overflow bit is cleared at result emit or clear. Once clamped, the accumulator continues from the clamped value. sat_flag is loaded with the window overflow bit alongside out.
- Undefined: wraparound arithmetic, sat_flag constant 0.

Test Plan:
- Config LANES=4, IF=FILTER=8, ACC_GUARD=4 (OUT_W=20). Single beat, all if=3, filter=2, last=1 at edge t -> out=24, out_valid=1 after edge t+3, busy falls after handshake.
- Three beats (if=1, filter=1,2,3 per beat across all lanes, last on third, back-to-back) -> one result out=24; no output for first two beats.
- out_ready=0 while a result is held, 5 beats streaming -> in_ready=0, out and stages frozen. Raise out_ready -> held result accepted, next window's result follows with correct sum, no beat lost or duplicated.
- Nine beats of if=-128, filter=127 on all lanes (per-beat -65024), last on ninth -> with PIPE_MAC_SAT_EN out=-524288, sat_flag=1; without the macro out=463360, sat_flag=0.
- Mid-window clear after two beats, then one beat if=2, filter=5, last -> out=40. The same mid-window rst pulse (async, between edges) -> outputs zero immediately; post-release single beat gives out=40.
- Back-to-back one-beat windows with out_ready=1 throughout -> out_valid stays 1 every cycle, each out matches its window, in_ready never drops.
